// File: rtl/seq_pkg.sv
// Constants and types shared between the stepper and the gate player.
package seq_pkg;

    localparam int unsigned NUM_STEPS = 8;
    localparam int unsigned STEP_W    = 4;
    localparam int unsigned ROW_W     = 4;

    typedef enum logic {
        IDLE,
        GATING
    } gate_state_t;

    typedef logic [ROW_W-1:0] pattern_row_t;

endpackage

// File: rtl/step_gate_player_gate_timer.sv
// Gate-length timer: loads a cycle count on each step event and stays active
// until the count runs out or the sequencer is stopped.
module gate_timer
    import seq_pkg::*;
#(
    parameter int unsigned GATE_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [GATE_W-1:0] i_len,
    input  logic              i_enable,
    output logic              o_active
);

    gate_state_t       r_state;
    logic [GATE_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (!i_enable) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (i_load) begin
            // A zero length still counts as an event but never opens the gate.
            if (i_len != '0) begin
                r_state <= GATING;
                r_cnt   <= i_len;
            end else begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end
        end else if (r_state == GATING) begin
            if (r_cnt <= GATE_W'(1)) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt - GATE_W'(1);
            end
        end
    end

    assign o_active = (r_state == GATING);

endmodule

// File: rtl/step_gate_player.sv
// Step-driven gate player: detects step advances, reads the pattern row for
// the new step and drives timed per-voice gates plus a one-cycle trigger.
module step_gate_player #(
    parameter int unsigned NUM_STEPS  = 8,
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned GATE_W     = 8
) (
    input  logic                        CLOCK,
    input  logic                        RESET,
    input  logic                        ENABLE,
    input  logic [seq_pkg::STEP_W-1:0]  STEP_NUM,
    input  logic [GATE_W-1:0]           GATE_LEN,
    input  logic                        WR_EN,
    input  logic [seq_pkg::STEP_W-1:0]  WR_STEP,
    input  logic [NUM_VOICES-1:0]       WR_PATTERN,
    output logic [NUM_VOICES-1:0]       GATE,
    output logic                        TRIGGER,
    output logic [seq_pkg::STEP_W-1:0]  CUR_STEP,
    output logic                        BUSY
);

    localparam int unsigned STEP_W = seq_pkg::STEP_W;
    localparam int unsigned IDX_W  = $clog2(NUM_STEPS);
    localparam logic [STEP_W:0] STEP_LIMIT = (STEP_W + 1)'(NUM_STEPS);

    logic [NUM_VOICES-1:0] r_pattern [NUM_STEPS];
    logic [NUM_VOICES-1:0] r_row;
    logic [STEP_W-1:0]     r_step_q;
    logic                  r_step_valid;
    logic                  r_trigger;

    logic                  w_step_ok;
    logic                  w_wr_ok;
    logic                  w_event;
    logic [NUM_VOICES-1:0] w_row;
    logic                  w_active;

    assign w_step_ok = ({1'b0, STEP_NUM} < STEP_LIMIT);
    assign w_wr_ok   = WR_EN && ({1'b0, WR_STEP} < STEP_LIMIT);
    assign w_event   = ENABLE && w_step_ok && (!r_step_valid || (STEP_NUM != r_step_q));

    // Same-cycle write to the row being stepped into wins over the stored data.
    assign w_row = (w_wr_ok && (WR_STEP == STEP_NUM)) ? WR_PATTERN
                                                      : r_pattern[STEP_NUM[IDX_W-1:0]];

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NUM_STEPS; i++) begin
                r_pattern[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_pattern[WR_STEP[IDX_W-1:0]] <= WR_PATTERN;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_row        <= '0;
            r_step_q     <= '0;
            r_step_valid <= 1'b0;
            r_trigger    <= 1'b0;
        end else begin
            r_trigger <= w_event;
            if (!ENABLE) begin
                r_step_valid <= 1'b0;
            end else if (w_event) begin
                r_row        <= w_row;
                r_step_q     <= STEP_NUM;
                r_step_valid <= 1'b1;
            end
        end
    end

    gate_timer #(
        .GATE_W(GATE_W)
    ) u_gate_timer (
        .i_clk    (CLOCK),
        .i_rst    (RESET),
        .i_load   (w_event),
        .i_len    (GATE_LEN),
        .i_enable (ENABLE),
        .o_active (w_active)
    );

    assign GATE     = w_active ? r_row : '0;
    assign TRIGGER  = r_trigger;
    assign CUR_STEP = r_step_q;
    assign BUSY     = w_active;

endmodule
